// File: rtl/rf_write_scheduler_pkg.sv
// Shared types and constants for the register-file write scheduler.
package rf_sched_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } rf_wr_t;

  // Owner of the register-file write port in the current cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_BUF  = 2'd2
  } wr_src_e;

  function automatic logic is_x0(input logic [REG_AW-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Bundle of writeback, load-issue/return, decode and register-file signals.
interface rf_write_scheduler_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned AW = rf_sched_pkg::REG_AW;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ld_issue_valid;
  logic [AW-1:0]   ld_issue_rd;
  logic            ld_ret_valid;
  logic [AW-1:0]   ld_ret_rd;
  logic [XLEN-1:0] ld_ret_data;
  logic            ld_ret_ready;
  logic [AW-1:0]   id_rs1;
  logic [AW-1:0]   id_rs2;
  logic [AW-1:0]   id_rd;
  logic            hazard_stall;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [NREG-1:0] pending_mask;
  logic [CW-1:0]   buf_count;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output ld_issue_valid, ld_issue_rd,
    output ld_ret_valid, ld_ret_rd, ld_ret_data,
    output id_rs1, id_rs2, id_rd,
    input  ld_ret_ready, hazard_stall,
    input  rf_we, rf_waddr, rf_wdata,
    input  pending_mask, buf_count
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  ld_issue_valid, ld_issue_rd,
    input  ld_ret_valid, ld_ret_rd, ld_ret_data,
    input  id_rs1, id_rs2, id_rd,
    output ld_ret_ready, hazard_stall,
    output rf_we, rf_waddr, rf_wdata,
    output pending_mask, buf_count
  );

endinterface

// File: rtl/rf_ret_fifo.sv
// Load-return buffer: DEPTH entries, registered push/pop, async reset.
module rf_ret_fifo
  import rf_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  rf_wr_t                     push_data,
  input  logic                       pop,
  output rf_wr_t                     head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  rf_wr_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates the register-file write port between writeback and late load
// returns, and tracks pending load destinations for the decode hazard stall.
module rf_write_scheduler #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  rf_write_scheduler_if.slave bus
);

  import rf_sched_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  rf_wr_t          head;
  rf_wr_t          ret_entry;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            accept;
  logic            push;
  logic            pop;
  wr_src_e         src;
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic            hazard;

  assign bus.ld_ret_ready = !full && !rst;
  assign accept           = bus.ld_ret_valid && bus.ld_ret_ready;
  assign push             = accept && !is_x0(bus.ld_ret_rd);
  assign ret_entry        = '{addr: bus.ld_ret_rd, data: bus.ld_ret_data};
  assign pop              = (src == SRC_BUF);

  rf_ret_fifo #(.DEPTH(DEPTH)) u_ret_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ret_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Writeback to x0 does not claim the port, so the buffer may drain then.
  always_comb begin
    src = SRC_NONE;
    if (rst)
      src = SRC_NONE;
    else if (bus.wb_valid && !is_x0(bus.wb_rd))
      src = SRC_WB;
    else if (!empty)
      src = SRC_BUF;
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    case (src)
      SRC_WB: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.wb_rd;
        bus.rf_wdata = bus.wb_data;
      end
      SRC_BUF: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = head.addr;
        bus.rf_wdata = head.data;
      end
      default: ;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    if (pop)
      pending_d[head.addr] = 1'b0;
    if (bus.ld_issue_valid && !is_x0(bus.ld_issue_rd))
      pending_d[bus.ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  always_comb begin
    hazard = 1'b0;
    if (!is_x0(bus.id_rs1)) hazard = hazard | pending_q[bus.id_rs1];
    if (!is_x0(bus.id_rs2)) hazard = hazard | pending_q[bus.id_rs2];
    if (!is_x0(bus.id_rd))  hazard = hazard | pending_q[bus.id_rd];
  end

  assign bus.hazard_stall = hazard;
  assign bus.pending_mask = pending_q;
  assign bus.buf_count    = count;

  a_issue_not_pending: assert property (@(posedge clk) disable iff (rst)
    (bus.ld_issue_valid && !is_x0(bus.ld_issue_rd)) |-> !pending_q[bus.ld_issue_rd]);

  a_wb_not_pending: assert property (@(posedge clk) disable iff (rst)
    (bus.wb_valid && !is_x0(bus.wb_rd)) |-> !pending_q[bus.wb_rd]);

  a_ret_is_pending: assert property (@(posedge clk) disable iff (rst)
    (accept && !is_x0(bus.ld_ret_rd)) |-> pending_q[bus.ld_ret_rd]);

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Scoreboard bench for rf_write_scheduler: expected port writes are queued as
// load returns are accepted and popped as the port is expected to carry them.
module tb_rf_write_scheduler;

  import rf_sched_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_write_scheduler_if #(.XLEN(32), .NREG(32), .DEPTH(DEPTH)) bus ();

  rf_write_scheduler #(.XLEN(32), .NREG(32), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          errors = 0;
  int          checks = 0;
  rf_wr_t      exp_q[$];
  logic [31:0] pend;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic model_stall();
    logic s;
    s = 1'b0;
    if (bus.id_rs1 != 0) s = s | pend[bus.id_rs1];
    if (bus.id_rs2 != 0) s = s | pend[bus.id_rs2];
    if (bus.id_rd  != 0) s = s | pend[bus.id_rd];
    return s;
  endfunction

  task automatic check_outputs();
    rf_wr_t e;
    logic   we;
    if (rst) begin
      check("rst_we",    bus.rf_we,        0);
      check("rst_waddr", bus.rf_waddr,     0);
      check("rst_wdata", bus.rf_wdata,     0);
      check("rst_ready", bus.ld_ret_ready, 0);
      check("rst_stall", bus.hazard_stall, 0);
      check("rst_count", bus.buf_count,    0);
      check("rst_mask",  bus.pending_mask, 0);
    end else begin
      if (bus.wb_valid && bus.wb_rd != 0) begin
        e  = '{addr: bus.wb_rd, data: bus.wb_data};
        we = 1'b1;
      end else if (exp_q.size() > 0) begin
        e  = exp_q[0];
        we = 1'b1;
      end else begin
        e  = '0;
        we = 1'b0;
      end
      check("rf_we",        bus.rf_we,        we);
      check("rf_waddr",     bus.rf_waddr,     e.addr);
      check("rf_wdata",     bus.rf_wdata,     e.data);
      check("ld_ret_ready", bus.ld_ret_ready, exp_q.size() < DEPTH);
      check("buf_count",    bus.buf_count,    exp_q.size());
      check("pending_mask", bus.pending_mask, pend);
      check("hazard_stall", bus.hazard_stall, model_stall());
    end
  endtask

  // Model effect of the coming rising edge, decided from pre-edge state.
  task automatic advance_model();
    logic drain;
    logic acc;
    if (!rst) begin
      drain = !(bus.wb_valid && bus.wb_rd != 0) && exp_q.size() > 0;
      acc   = bus.ld_ret_valid && exp_q.size() < DEPTH;
      if (drain) begin
        pend[exp_q[0].addr] = 1'b0;
        void'(exp_q.pop_front());
      end
      if (bus.ld_issue_valid && bus.ld_issue_rd != 0) pend[bus.ld_issue_rd] = 1'b1;
      if (acc && bus.ld_ret_rd != 0)
        exp_q.push_back('{addr: bus.ld_ret_rd, data: bus.ld_ret_data});
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    advance_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.ld_issue_valid = 0; bus.ld_issue_rd = 0;
    bus.ld_ret_valid = 0; bus.ld_ret_rd = 0; bus.ld_ret_data = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.ld_issue_valid = 1; bus.ld_issue_rd = rd;
    step();
    bus.ld_issue_valid = 0; bus.ld_issue_rd = 0;
  endtask

  task automatic set_ret(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.ld_ret_valid = v; bus.ld_ret_rd = rd; bus.ld_ret_data = d;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.wb_valid = v; bus.wb_rd = rd; bus.wb_data = d;
  endtask

  initial begin
    int waited;
    logic got;
    pend = '0;
    rst  = 1'b1;
    idle_inputs();
    repeat (2) step();
    rst = 1'b0;
    step();

    // Reset in the middle of outstanding work.
    issue(5'd5);
    issue(5'd6);
    set_wb(1, 5'd3, 32'h3333_0000);
    set_ret(1, 5'd5, 32'hAAAA_0005); step();
    set_ret(1, 5'd6, 32'hAAAA_0006); step();
    set_ret(0, 0, 0);
    step();
    #2 rst = 1'b1;
    #1 check_outputs();
    exp_q.delete();
    pend = '0;
    set_wb(0, 0, 0);
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    repeat (3) step();

    // Basic load path with RAW stall.
    issue(5'd5);
    bus.id_rs1 = 5'd5;
    step();
    set_ret(1, 5'd5, 32'hDEAD_BEEF); step();
    set_ret(0, 0, 0);
    @(negedge clk);
    check("basic_we",    bus.rf_we,    1);
    check("basic_waddr", bus.rf_waddr, 5);
    check("basic_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    pend[5] = 1'b0;
    check("basic_stall_cleared", bus.hazard_stall, 0);
    step();
    bus.id_rs1 = 0;

    // Writeback holds the port for three cycles, buffered x7 follows.
    issue(5'd7);
    set_wb(1, 5'd3, 32'h22);
    set_ret(1, 5'd7, 32'h11); step();
    set_ret(0, 0, 0);
    repeat (2) step();
    set_wb(0, 0, 0);
    step();
    step();

    // x0 corner cases.
    issue(5'd9);
    set_wb(1, 5'd3, 32'h44);
    set_ret(1, 5'd9, 32'h99); step();
    set_ret(0, 0, 0);
    set_wb(1, 5'd0, 32'hFFFF_FFFF); step();
    set_wb(0, 0, 0);
    set_ret(1, 5'd0, 32'h1234); step();
    set_ret(0, 0, 0);
    step();
    issue(5'd0);
    issue(5'd6);
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0; step();
    bus.id_rd = 5'd6; step();
    bus.id_rd = 0;
    set_ret(1, 5'd6, 32'h6666); step();
    set_ret(0, 0, 0);
    repeat (2) step();

    // Fill the buffer while writeback owns the port.
    for (int r = 10; r <= 14; r++) issue(5'(r));
    set_wb(1, 5'd3, 32'h55);
    for (int r = 10; r <= 13; r++) begin
      set_ret(1, 5'(r), 32'hA000_0000 + 32'(r));
      step();
    end
    set_ret(1, 5'd14, 32'hA000_000E);
    check("full_ready_low", bus.ld_ret_ready, 0);
    check("full_count", bus.buf_count, 4);
    repeat (2) step();
    set_wb(0, 0, 0);
    got = 1'b0;
    waited = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.ld_ret_ready) got = 1'b1;
      step();
      if (got) break;
      waited++;
    end
    check("ret5_accepted", got, 1);
    check("ret5_wait_cycles", waited, 1);
    set_ret(0, 0, 0);
    repeat (6) step();

    // Same-edge clear of x4 and set of x8.
    issue(5'd4);
    set_wb(1, 5'd3, 32'h77);
    set_ret(1, 5'd4, 32'h4444); step();
    set_ret(0, 0, 0);
    set_wb(0, 0, 0);
    bus.ld_issue_valid = 1; bus.ld_issue_rd = 5'd8;
    step();
    bus.ld_issue_valid = 0; bus.ld_issue_rd = 0;
    check("same_edge_pend4", bus.pending_mask[4], 0);
    check("same_edge_pend8", bus.pending_mask[8], 1);
    bus.id_rs2 = 5'd8; step();
    bus.id_rs2 = 0;
    set_ret(1, 5'd8, 32'h8888); step();
    set_ret(0, 0, 0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected completion before 200000");
    $fatal(1);
  end

endmodule
